// File: rtl/cd_config_sequencer.sv
// Arbitrates two config requesters onto the clock-divider config port, one write in flight.
// Optional CFG_SEQ_DEDUP_EN: skip writes whose field matches the last acknowledged value.
module cd_config_sequencer #(
  parameter int WIDTH_CONFIG_ADDR = 2,
  parameter int WIDTH_CONFIG_DATA = 8,
  parameter int TIMEOUT_CYCLES    = 16,
  parameter int WIDTH_TIMEOUT     = 5
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         req0_valid_i,
  input  logic [WIDTH_CONFIG_ADDR-1:0] req0_addr_i,
  input  logic [WIDTH_CONFIG_DATA-1:0] req0_data_i,
  output logic                         req0_ready_o,
  output logic                         req0_done_o,
  output logic                         req0_err_o,
  input  logic                         req1_valid_i,
  input  logic [WIDTH_CONFIG_ADDR-1:0] req1_addr_i,
  input  logic [WIDTH_CONFIG_DATA-1:0] req1_data_i,
  output logic                         req1_ready_o,
  output logic                         req1_done_o,
  output logic                         req1_err_o,
  output logic [WIDTH_CONFIG_ADDR-1:0] c_addr_o,
  output logic [WIDTH_CONFIG_DATA-1:0] c_data_o,
  output logic                         c_valid_o,
  input  logic                         c_UART_ready_i,
  input  logic                         c_VGA_ready_i,
  output logic                         busy_o
);

  // state | meaning: IDLE arbitrate | ISSUE c_valid out | WAIT_ACK await ack | REJECT bad addr | SKIP dedup hit
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT_ACK, S_REJECT, S_SKIP} state_t;

  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_UART = WIDTH_CONFIG_ADDR'(1);
  localparam logic [WIDTH_CONFIG_ADDR-1:0] ADDR_VGA  = WIDTH_CONFIG_ADDR'(2);
  localparam logic [WIDTH_TIMEOUT-1:0]     TO_LOAD   = WIDTH_TIMEOUT'(TIMEOUT_CYCLES - 1);

  state_t                         state_q, state_d;
  logic [WIDTH_TIMEOUT-1:0]       cnt_q, cnt_d;
  logic                           rr_q, rr_d;
  logic                           gnt_q, gnt_d;
  logic [WIDTH_CONFIG_ADDR-1:0]   c_addr_q, c_addr_d;
  logic [WIDTH_CONFIG_DATA-1:0]   c_data_q, c_data_d;
  logic                           c_valid_q, c_valid_d;
  logic [1:0]                     ready_q, ready_d;
  logic [1:0]                     done_q, done_d;
  logic [1:0]                     err_q, err_d;
  logic                           busy_q, busy_d;

  logic                           win;
  logic [WIDTH_CONFIG_ADDR-1:0]   win_addr;
  logic [WIDTH_CONFIG_DATA-1:0]   win_data;
  logic                           win_addr_ok;
  logic                           ack;
  logic                           dedup_hit;

  // rr_q names the requester favoured when both are valid
  assign win         = (req0_valid_i && req1_valid_i) ? rr_q : req1_valid_i;
  assign win_addr    = win ? req1_addr_i : req0_addr_i;
  assign win_data    = win ? req1_data_i : req0_data_i;
  assign win_addr_ok = (win_addr == ADDR_UART) || (win_addr == ADDR_VGA);
  assign ack         = ((c_addr_q == ADDR_UART) && c_UART_ready_i) ||
                       ((c_addr_q == ADDR_VGA)  && c_VGA_ready_i);

`ifdef CFG_SEQ_DEDUP_EN
  logic [2:0] sh_uart_q;
  logic [1:0] sh_vga_q;
  logic       sh_uart_vld_q;
  logic       sh_vga_vld_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sh_uart_q     <= '0;
      sh_vga_q      <= '0;
      sh_uart_vld_q <= 1'b0;
      sh_vga_vld_q  <= 1'b0;
    end else if (state_q == S_WAIT_ACK && ack) begin
      if (c_addr_q == ADDR_UART) begin
        sh_uart_q     <= c_data_q[4:2];
        sh_uart_vld_q <= 1'b1;
      end else begin
        sh_vga_q     <= c_data_q[4:3];
        sh_vga_vld_q <= 1'b1;
      end
    end
  end

  assign dedup_hit = ((win_addr == ADDR_UART) && sh_uart_vld_q && (win_data[4:2] == sh_uart_q)) ||
                     ((win_addr == ADDR_VGA)  && sh_vga_vld_q  && (win_data[4:3] == sh_vga_q));
`else
  assign dedup_hit = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    rr_d      = rr_q;
    gnt_d     = gnt_q;
    c_addr_d  = c_addr_q;
    c_data_d  = c_data_q;
    c_valid_d = 1'b0;
    ready_d   = '0;
    done_d    = '0;
    err_d     = '0;
    case (state_q)
      S_IDLE: begin
        if (req0_valid_i || req1_valid_i) begin
          gnt_d        = win;
          rr_d         = ~win;
          ready_d[win] = 1'b1;
          if (!win_addr_ok) begin
            state_d = S_REJECT;
          end else if (dedup_hit) begin
            state_d = S_SKIP;
          end else begin
            state_d   = S_ISSUE;
            c_valid_d = 1'b1;
            c_addr_d  = win_addr;
            c_data_d  = win_data;
          end
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_ACK;
        cnt_d   = TO_LOAD;
      end
      S_WAIT_ACK: begin
        if (ack) begin
          done_d[gnt_q] = 1'b1;
          state_d       = S_IDLE;
        end else if (cnt_q == '0) begin
          err_d[gnt_q] = 1'b1;
          state_d      = S_IDLE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_REJECT: begin
        err_d[gnt_q] = 1'b1;
        state_d      = S_IDLE;
      end
      S_SKIP: begin
        done_d[gnt_q] = 1'b1;
        state_d       = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      rr_q      <= 1'b0;
      gnt_q     <= 1'b0;
      c_addr_q  <= '0;
      c_data_q  <= '0;
      c_valid_q <= 1'b0;
      ready_q   <= '0;
      done_q    <= '0;
      err_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rr_q      <= rr_d;
      gnt_q     <= gnt_d;
      c_addr_q  <= c_addr_d;
      c_data_q  <= c_data_d;
      c_valid_q <= c_valid_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= busy_d;
    end
  end

  assign req0_ready_o = ready_q[0];
  assign req1_ready_o = ready_q[1];
  assign req0_done_o  = done_q[0];
  assign req1_done_o  = done_q[1];
  assign req0_err_o   = err_q[0];
  assign req1_err_o   = err_q[1];
  assign c_addr_o     = c_addr_q;
  assign c_data_o     = c_data_q;
  assign c_valid_o    = c_valid_q;
  assign busy_o       = busy_q;

endmodule

// File: tb/tb_cd_config_sequencer.sv
// Directed bench for cd_config_sequencer: vector table of transactions plus reset sequences.
// Honours CFG_SEQ_DEDUP_EN for the duplicate-write expectation.
module tb_cd_config_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid, req1_valid;
  logic [1:0] req0_addr, req1_addr;
  logic [7:0] req0_data, req1_data;
  logic       req0_ready, req0_done, req0_err;
  logic       req1_ready, req1_done, req1_err;
  logic [1:0] c_addr;
  logic [7:0] c_data;
  logic       c_valid;
  logic       c_UART_ready, c_VGA_ready;
  logic       busy;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  cd_config_sequencer dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req0_valid_i   (req0_valid),
    .req0_addr_i    (req0_addr),
    .req0_data_i    (req0_data),
    .req0_ready_o   (req0_ready),
    .req0_done_o    (req0_done),
    .req0_err_o     (req0_err),
    .req1_valid_i   (req1_valid),
    .req1_addr_i    (req1_addr),
    .req1_data_i    (req1_data),
    .req1_ready_o   (req1_ready),
    .req1_done_o    (req1_done),
    .req1_err_o     (req1_err),
    .c_addr_o       (c_addr),
    .c_data_o       (c_data),
    .c_valid_o      (c_valid),
    .c_UART_ready_i (c_UART_ready),
    .c_VGA_ready_i  (c_VGA_ready),
    .busy_o         (busy)
  );

  // Times are cycle offsets after the request is first sampled (1 = N+1); 0 = never.
  typedef struct {
    bit       v0;
    bit [1:0] a0;
    bit [7:0] d0;
    bit       v1;
    bit [1:0] a1;
    bit [7:0] d1;
    int       dly;
    bit       spur;
    int       r0, dn0, er0;
    int       r1, dn1, er1;
    int       ncv;
  } vec_t;

  vec_t vecs[12];
  vec_t post_rst_vec;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int all_outs();
    return int'({c_addr, c_data, c_valid, busy, req0_ready, req0_done, req0_err,
                 req1_ready, req1_done, req1_err});
  endfunction

  task automatic run_vec(input vec_t v, input string tag);
    int t_rdy[2], n_rdy[2], t_dn[2], n_dn[2], t_er[2], n_er[2];
    int ncv, viol, ack_t;
    logic [1:0] ack_addr, rdy, dn, er, exp_a;
    logic [7:0] exp_d;
    bit cv_seen;
    int exp_r[2], exp_dn[2], exp_er[2];
    exp_r  = '{v.r0, v.r1};
    exp_dn = '{v.dn0, v.dn1};
    exp_er = '{v.er0, v.er1};
    for (int i = 0; i < 2; i++) begin
      t_rdy[i] = 0; n_rdy[i] = 0; t_dn[i] = 0; n_dn[i] = 0; t_er[i] = 0; n_er[i] = 0;
    end
    ncv = 0; viol = 0; ack_t = -1; ack_addr = 2'b00; cv_seen = 1'b0;
    req0_valid = v.v0; req0_addr = v.a0; req0_data = v.d0;
    req1_valid = v.v1; req1_addr = v.a1; req1_data = v.d1;
    c_UART_ready = 1'b0; c_VGA_ready = 1'b0;
    for (int t = 1; t <= 30; t++) begin
      @(posedge clk);
      @(negedge clk);
      rdy = {req1_ready, req0_ready};
      dn  = {req1_done, req0_done};
      er  = {req1_err, req0_err};
      for (int i = 0; i < 2; i++) begin
        if (rdy[i]) begin n_rdy[i]++; if (t_rdy[i] == 0) t_rdy[i] = t; end
        if (dn[i])  begin n_dn[i]++;  if (t_dn[i] == 0)  t_dn[i] = t;  end
        if (er[i])  begin n_er[i]++;  if (t_er[i] == 0)  t_er[i] = t;  end
        if (dn[i] && er[i]) viol++;
      end
      if ((rdy[0] || dn[0] || er[0]) && (rdy[1] || dn[1] || er[1])) viol++;
      if ((dn != 2'b00 || er != 2'b00) && busy) viol++;
      if (rdy[0]) req0_valid = 1'b0;
      if (rdy[1]) req1_valid = 1'b0;
      if (c_valid) begin
        ncv++;
        cv_seen  = 1'b1;
        ack_addr = c_addr;
        ack_t    = (v.dly > 0) ? t + v.dly : -1;
        if (rdy == 2'b01) begin exp_a = v.a0; exp_d = v.d0; end
        else if (rdy == 2'b10) begin exp_a = v.a1; exp_d = v.d1; end
        else begin exp_a = 2'b00; exp_d = 8'h00; viol++; end
        chk($sformatf("%s c_addr", tag), int'(c_addr), int'(exp_a));
        chk($sformatf("%s c_data", tag), int'(c_data), int'(exp_d));
      end
      c_UART_ready = (t == ack_t && ack_addr == 2'b01) || (v.spur && cv_seen && ack_addr == 2'b10);
      c_VGA_ready  = (t == ack_t && ack_addr == 2'b10) || (v.spur && cv_seen && ack_addr == 2'b01);
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    c_UART_ready = 1'b0; c_VGA_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("%s ready%0d time", tag, i), t_rdy[i], exp_r[i]);
      chk($sformatf("%s ready%0d pulses", tag, i), n_rdy[i], (exp_r[i] != 0) ? 1 : 0);
      chk($sformatf("%s done%0d time", tag, i), t_dn[i], exp_dn[i]);
      chk($sformatf("%s done%0d pulses", tag, i), n_dn[i], (exp_dn[i] != 0) ? 1 : 0);
      chk($sformatf("%s err%0d time", tag, i), t_er[i], exp_er[i]);
      chk($sformatf("%s err%0d pulses", tag, i), n_er[i], (exp_er[i] != 0) ? 1 : 0);
    end
    chk($sformatf("%s c_valid pulses", tag), ncv, v.ncv);
    chk($sformatf("%s protocol violations", tag), viol, 0);
    chk($sformatf("%s busy idle", tag), int'(busy), 0);
  endtask

  initial begin
    int stray;
    //          v0 a0    d0     v1 a1    d1     dly spur r0 dn0 er0 r1 dn1 er1 ncv
    vecs[0]  = '{1, 2'b01, 8'h08, 0, 2'b00, 8'h00, 1,  0,  1, 3,  0,  0, 0,  0,  1};
    vecs[1]  = '{1, 2'b10, 8'h18, 1, 2'b01, 8'h10, 1,  0,  4, 6,  0,  1, 3,  0,  2};
    vecs[2]  = '{1, 2'b01, 8'h04, 1, 2'b10, 8'h08, 1,  0,  4, 6,  0,  1, 3,  0,  2};
    vecs[3]  = '{0, 2'b00, 8'h00, 1, 2'b10, 8'h10, 0,  1,  0, 0,  0,  1, 0,  18, 1};
    vecs[4]  = '{1, 2'b11, 8'h55, 0, 2'b00, 8'h00, 0,  0,  1, 0,  2,  0, 0,  0,  0};
    vecs[5]  = '{0, 2'b00, 8'h00, 1, 2'b00, 8'hAA, 0,  0,  0, 0,  0,  1, 0,  2,  0};
    vecs[6]  = '{1, 2'b10, 8'h00, 0, 2'b00, 8'h00, 16, 0,  1, 18, 0,  0, 0,  0,  1};
    vecs[7]  = '{1, 2'b01, 8'h1C, 0, 2'b00, 8'h00, 17, 0,  1, 0,  18, 0, 0,  0,  1};
    vecs[8]  = '{1, 2'b01, 8'h1C, 0, 2'b00, 8'h00, 1,  0,  1, 3,  0,  0, 0,  0,  1};
    vecs[9]  = '{1, 2'b01, 8'h0C, 0, 2'b00, 8'h00, 1,  0,  1, 3,  0,  0, 0,  0,  1};
`ifdef CFG_SEQ_DEDUP_EN
    vecs[10] = '{1, 2'b01, 8'h0C, 0, 2'b00, 8'h00, 1,  0,  1, 2,  0,  0, 0,  0,  0};
`else
    vecs[10] = '{1, 2'b01, 8'h0C, 0, 2'b00, 8'h00, 1,  0,  1, 3,  0,  0, 0,  0,  1};
`endif
    vecs[11] = '{0, 2'b00, 8'h00, 1, 2'b10, 8'h18, 2,  1,  0, 0,  0,  1, 4,  0,  1};
    post_rst_vec = '{1, 2'b01, 8'h0C, 0, 2'b00, 8'h00, 1, 0, 1, 3, 0, 0, 0, 0, 1};

    rst = 1'b1;
    req0_valid = 1'b0; req0_addr = 2'b00; req0_data = 8'h00;
    req1_valid = 1'b0; req1_addr = 2'b00; req1_data = 8'h00;
    c_UART_ready = 1'b0; c_VGA_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("reset outputs", all_outs(), 0);
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("idle after reset", all_outs(), 0);

    for (int i = 0; i < 12; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // reset during WAIT_ACK drops the write silently
    req0_valid = 1'b1; req0_addr = 2'b01; req0_data = 8'h08;
    @(posedge clk);
    @(negedge clk);
    chk("rst seq ready0", int'(req0_ready), 1);
    req0_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    chk("rst seq busy in wait", int'(busy), 1);
    rst = 1'b1;
    c_UART_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst seq outputs", all_outs(), 0);
    rst = 1'b0;
    c_UART_ready = 1'b0;
    stray = 0;
    repeat (5) begin
      @(posedge clk);
      @(negedge clk);
      if (req0_done || req0_err || req1_done || req1_err || busy) stray++;
    end
    chk("rst seq no done/err", stray, 0);
    run_vec(post_rst_vec, "post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
